// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - stream input and RAM write port of the program loader
interface prog_loader_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_addr, ram_data, ram_we
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed-stream program loader: writes payload to RAM, verifies checksum, releases CPU
module prog_loader #(
  parameter int DW        = 8,
  parameter int AW        = 4,
  parameter bit ZERO_FILL = 1'b0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [AW-1:0] load_base,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   word_count
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_FILL, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW:0]   word_count_q, word_count_d;
  logic [DW-1:0] csum_q, csum_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   fill_idx_q, fill_idx_d;

  logic accept, start_ok, len_bad, csum_ok, data_last, fill_last;
  int   hdr_len;

  assign accept    = bus.in_valid && in_ready_q;
  assign start_ok  = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign hdr_len   = int'(bus.in_data);
  assign len_bad   = (hdr_len == 0) || (hdr_len > DEPTH);
  assign csum_ok   = (bus.in_data == csum_q);
  assign data_last = ((word_count_q + ONE_W) == len_q);
  // Fill covers exactly the DEPTH-LEN locations outside the payload window.
  assign fill_last = ((fill_idx_q + ONE_W) == (DEPTH_W - len_q));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) state_d = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (accept && data_last) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (accept) begin
          if (!csum_ok) begin
            state_d = S_ERR;
          end else if (ZERO_FILL && (len_q != DEPTH_W)) begin
            state_d = S_FILL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FILL: begin
        if (fill_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state, so they line up with state_q.
  always_comb begin
    in_ready_d   = state_d inside {S_HDR, S_DATA, S_CSUM};
    cpu_hold_d   = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    word_count_d = word_count_q;
    csum_d       = csum_q;
    len_d        = len_q;
    base_d       = base_q;
    fill_idx_d   = fill_idx_q;

    if (start_ok) begin
      base_d       = load_base;
      word_count_d = '0;
    end

    case (state_q)
      S_HDR: begin
        if (accept && !len_bad) begin
          len_d        = (AW+1)'(bus.in_data);
          csum_d       = '0;
          word_count_d = '0;
        end
      end
      S_DATA: begin
        if (accept) begin
          ram_we_d     = 1'b1;
          ram_addr_d   = base_q + word_count_q[AW-1:0];
          ram_data_d   = bus.in_data;
          word_count_d = word_count_q + ONE_W;
          csum_d       = csum_q + bus.in_data;
        end
      end
      S_CSUM: begin
        if (accept) fill_idx_d = '0;
      end
      S_FILL: begin
        ram_we_d   = 1'b1;
        ram_addr_d = base_q + len_q[AW-1:0] + fill_idx_q[AW-1:0];
        ram_data_d = '0;
        fill_idx_d = fill_idx_q + ONE_W;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      in_ready_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      csum_q       <= '0;
      len_q        <= '0;
      base_q       <= '0;
      fill_idx_q   <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
      csum_q       <= csum_d;
      len_q        <= len_d;
      base_q       <= base_d;
      fill_idx_q   <= fill_idx_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign word_count   = word_count_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table and randomized checks of prog_loader (plain and zero-fill) against a RAM-level model
module tb_prog_loader;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          cpu_hold0, done0, error0, cpu_hold1, done1, error1;
  logic [AW:0]   wc0, wc1;

  always #5 clk = ~clk;

  prog_loader_if #(.DW(DW), .AW(AW)) if0 ();
  prog_loader_if #(.DW(DW), .AW(AW)) if1 ();
  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;

  prog_loader #(.DW(DW), .AW(AW), .ZERO_FILL(1'b0)) dut0 (
    .clk(clk), .clr(clr), .start(start), .load_base(load_base), .bus(if0),
    .cpu_hold(cpu_hold0), .done(done0), .error(error0), .word_count(wc0)
  );
  prog_loader #(.DW(DW), .AW(AW), .ZERO_FILL(1'b1)) dut1 (
    .clk(clk), .clr(clr), .start(start), .load_base(load_base), .bus(if1),
    .cpu_hold(cpu_hold1), .done(done1), .error(error1), .word_count(wc1)
  );

  logic [7:0] ram0 [DEPTH];
  logic [7:0] ram1 [DEPTH];
  logic [7:0] exp0 [DEPTH];
  logic [7:0] exp1 [DEPTH];
  int         wr0 = 0;
  int         wr1 = 0;
  logic       init0 = 1'b0;
  logic       init1 = 1'b0;
  logic [7:0] init_val = 8'h00;

  always @(posedge clk) begin
    if (init0) begin
      for (int k = 0; k < DEPTH; k++) ram0[k] <= init_val;
    end else if (if0.ram_we) begin
      ram0[if0.ram_addr] <= if0.ram_data;
      wr0 <= wr0 + 1;
    end
    if (init1) begin
      for (int k = 0; k < DEPTH; k++) ram1[k] <= init_val;
    end else if (if1.ram_we) begin
      ram1[if1.ram_addr] <= if1.ram_data;
      wr1 <= wr1 + 1;
    end
  end

  typedef struct {
    logic [3:0]  base;
    int          n;
    logic [47:0] words;
    bit          prefill;
    int          ed;
    int          ee;
    int          wc;
  } vec_t;

  vec_t       tab [NV];
  logic [7:0] stream [$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         noise = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic do_start(input logic [3:0] base);
    @(negedge clk);
    start = 1'b1;
    load_base = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] w);
    int t = 0;
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data = w;
    if (noise) begin
      start = ($urandom_range(0, 3) == 0);
      load_base = 4'($urandom);
    end
    while (!if0.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
      start = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!((done0 || error0) && (done1 || error1)) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("finish_within_budget", (t < 200) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Expected RAM effect of the current stream, described as sets of addresses.
  task automatic model_run(input logic [3:0] base, output int md, output int me,
                           output int mwc, output int mw0, output int mw1);
    int len;
    int sum;
    md = 0; me = 0; mwc = 0; mw0 = 0; mw1 = 0; sum = 0;
    len = int'(stream[0]);
    if (len == 0 || len > DEPTH) begin
      me = 1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp0[(int'(base) + i) % DEPTH] = stream[1+i];
      exp1[(int'(base) + i) % DEPTH] = stream[1+i];
      sum = (sum + int'(stream[1+i])) % 256;
    end
    mwc = len; mw0 = len; mw1 = len;
    if (int'(stream[len+1]) == sum) begin
      md = 1;
      for (int a = 0; a < DEPTH; a++) begin
        if (((a - int'(base) + DEPTH) % DEPTH) >= len) begin
          exp1[a] = 8'h00;
          mw1++;
        end
      end
    end else begin
      me = 1;
    end
  endtask

  task automatic check_rams(input string name);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("%s_ram0[%0d]", name, k), int'(ram0[k]), int'(exp0[k]));
      chk($sformatf("%s_ram1[%0d]", name, k), int'(ram1[k]), int'(exp1[k]));
    end
  endtask

  task automatic run_load(input string name, input logic [3:0] base, input bit use_tab,
                          input int ted, input int tee, input int twc);
    int md, me, mwc, mw0, mw1, s0, s1;
    s0 = wr0;
    s1 = wr1;
    do_start(base);
    foreach (stream[i]) push(stream[i]);
    wait_done();
    model_run(base, md, me, mwc, mw0, mw1);
    if (use_tab) begin
      md = ted; me = tee; mwc = twc;
    end
    chk({name, "_done0"}, int'(done0), md);
    chk({name, "_error0"}, int'(error0), me);
    chk({name, "_hold0"}, int'(cpu_hold0), md ? 0 : 1);
    chk({name, "_wc0"}, int'(wc0), mwc);
    chk({name, "_writes0"}, wr0 - s0, mw0);
    chk({name, "_done1"}, int'(done1), md);
    chk({name, "_error1"}, int'(error1), me);
    chk({name, "_hold1"}, int'(cpu_hold1), md ? 0 : 1);
    chk({name, "_wc1"}, int'(wc1), mwc);
    chk({name, "_writes1"}, wr1 - s1, mw1);
    check_rams(name);
  endtask

  task automatic gen_random();
    int r, len, sum;
    logic [7:0] w;
    stream.delete();
    r = $urandom_range(0, 9);
    if (r == 0) begin
      stream.push_back(8'h00);
      return;
    end
    if (r == 1) begin
      stream.push_back(8'($urandom_range(17, 255)));
      return;
    end
    len = (r == 2) ? DEPTH : $urandom_range(1, DEPTH);
    stream.push_back(8'(len));
    sum = 0;
    for (int i = 0; i < len; i++) begin
      w = 8'($urandom);
      stream.push_back(w);
      sum = sum + int'(w);
    end
    if ($urandom_range(0, 4) == 0) stream.push_back(8'(sum + $urandom_range(1, 255)));
    else stream.push_back(8'(sum));
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_hold0"}, int'(cpu_hold0), 1);
    chk({name, "_done0"}, int'(done0), 0);
    chk({name, "_error0"}, int'(error0), 0);
    chk({name, "_ready0"}, int'(if0.in_ready), 0);
    chk({name, "_we0"}, int'(if0.ram_we), 0);
    chk({name, "_addr0"}, int'(if0.ram_addr), 0);
    chk({name, "_data0"}, int'(if0.ram_data), 0);
    chk({name, "_wc0"}, int'(wc0), 0);
    chk({name, "_hold1"}, int'(cpu_hold1), 1);
    chk({name, "_ready1"}, int'(if1.in_ready), 0);
    chk({name, "_wc1"}, int'(wc1), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [7:0] w1, w2;
    int s0;

    tab[0] = '{4'h0, 6, 48'h04_1E_2F_E0_F0_1D, 1'b0, 1, 0, 4};
    tab[1] = '{4'hE, 4, 48'h02_38_23_5B_00_00, 1'b0, 1, 0, 2};
    tab[2] = '{4'hF, 4, 48'h02_AA_BB_00_00_00, 1'b0, 0, 1, 2};
    tab[3] = '{4'hF, 4, 48'h02_AA_BB_65_00_00, 1'b0, 1, 0, 2};
    tab[4] = '{4'h3, 1, 48'h00_00_00_00_00_00, 1'b0, 0, 1, 0};
    tab[5] = '{4'h5, 1, 48'h11_00_00_00_00_00, 1'b0, 0, 1, 0};
    tab[6] = '{4'h0, 4, 48'h02_11_22_33_00_00, 1'b1, 1, 0, 2};

    #2 clr = 1'b0;
    #1 reset_checks("reset");
    init0 = 1'b1;
    init1 = 1'b1;
    init_val = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      exp0[k] = 8'h00;
      exp1[k] = 8'h00;
    end
    repeat (2) @(negedge clk);
    init0 = 1'b0;
    init1 = 1'b0;
    clr = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      if (tab[v].prefill) begin
        init1 = 1'b1;
        init_val = 8'hFF;
        for (int k = 0; k < DEPTH; k++) exp1[k] = 8'hFF;
        @(negedge clk);
        init1 = 1'b0;
      end
      stream.delete();
      for (int j = 0; j < tab[v].n; j++) stream.push_back(tab[v].words[47-8*j -: 8]);
      run_load($sformatf("tab%0d", v), tab[v].base, 1'b1, tab[v].ed, tab[v].ee, tab[v].wc);
    end

    // Words offered while the loader is not ready must not be consumed.
    s0 = wr0;
    in_valid = 1'b1;
    in_data = 8'h03;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_valid_writes", wr0 - s0, 0);
    chk("idle_valid_done", int'(done0), 1);
    chk("idle_valid_ready", int'(if0.in_ready), 0);

    // Asynchronous reset in the middle of a payload.
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    stream.delete();
    stream.push_back(8'h05);
    stream.push_back(w1);
    stream.push_back(w2);
    do_start(4'h4);
    foreach (stream[i]) push(stream[i]);
    @(negedge clk);
    #2 clr = 1'b0;
    #1 reset_checks("mid_reset");
    exp0[4] = w1; exp0[5] = w2;
    exp1[4] = w1; exp1[5] = w2;
    @(negedge clk);
    clr = 1'b1;
    check_rams("mid_reset");
    gen_random();
    run_load("after_reset", 4'h4, 1'b0, 0, 0, 0);

    noise = 1'b1;
    for (int i = 0; i < 25; i++) begin
      gen_random();
      run_load($sformatf("rnd%0d", i), 4'($urandom), 1'b0, 0, 0, 0);
    end
    noise = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware program loader for the simple computer.
- Accepts a framed word stream (length, payload, checksum) over a valid/ready handshake and writes the payload into RAM starting at a base address.
- Holds the CPU off until a load verifies, then releases it.
- Parametrised in data width and address depth, with an optional zero-fill mode for unused RAM. This replaces manual poking of board RAM before releasing clear.

Parameters:
- DW, 8, RAM/stream word width in bits
- AW, 4, RAM address width; DEPTH = 2**AW
- ZERO_FILL, 0, when 1 every RAM location not written by the payload is written with 0 after a successful checksum

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- load_base  in  AW  first RAM address to write; sampled on the cycle start is honoured
- in_valid  in  1  stream word valid
- in_data  in  DW  stream word
- in_ready  out  1  loader can accept in_data this cycle
- ram_addr  out  AW  RAM write address
- ram_data  out  DW  RAM write data
- ram_we  out  1  RAM write strobe, one cycle per word
- cpu_hold  out  1  1 = CPU held in clear
- done  out  1  load completed and verified
- error  out  1  load rejected
- word_count  out  AW+1  payload words written in the current or last load

Behaviour:
- Reset (clr=0, asynchronous) forces all of the following immediately:
  - state=IDLE, cpu_hold=1, done=0, error=0, ram_we=0, in_ready=0
  - ram_addr=0, ram_data=0, word_count=0, internal checksum=0
- RAM contents are not erased by reset; a reset mid-load leaves partially written words in place.
- A word transfers on a rising edge where in_valid=1 and in_ready=1. in_ready is a registered output.
- State HDR:
  - in_ready=1; the accepted word is LEN.
  - LEN=0 or LEN>DEPTH → ERR.
  - Otherwise store LEN, clear checksum and word_count → DATA.
- State DATA:
  - in_ready=1; one payload word per cycle at full rate.
  - On the cycle after each acceptance: ram_we=1, ram_addr=base+index (mod DEPTH), ram_data=word.
  - word_count increments on each acceptance.
  - Checksum updates as checksum = (checksum + word) mod 2**DW.
  - After the LEN-th word → CSUM.
- Address wrap: base+index beyond DEPTH-1 wraps to 0. Words are never dropped.
- State CSUM:
  - in_ready=1; the accepted word is compared with the checksum.
  - Mismatch → ERR.
  - Match → FILL if ZERO_FILL=1, else DONE.
- State FILL:
  - in_ready=0; one write per cycle with ram_data=0, covering the DEPTH-LEN addresses not in the payload window, ascending from base+LEN (mod DEPTH).
  - Then → DONE. With LEN=DEPTH, FILL takes zero cycles.
- State DONE: done=1, cpu_hold=0, in_ready=0.
- State ERR: error=1, cpu_hold=1, in_ready=0.
- IDLE, DONE and ERR accept start → HDR. On that edge:
  - cpu_hold=1, done=0, error=0
  - load_base latched, word_count cleared
- start in HDR/DATA/CSUM/FILL is ignored.
- in_valid while in_ready=0 is ignored; no word is consumed.
- in_valid may drop at any time in HDR/DATA/CSUM; the loader waits indefinitely with no timeout.
- ram_we is never asserted outside the cycle following a DATA acceptance or a FILL cycle.

Test Plan:
- Basic load: reset, start with load_base=0, stream 04,1E,2F,E0,F0,1D →
  - RAM[0..3]=1E,2F,E0,F0; four ram_we pulses
  - word_count=4, done=1, cpu_hold=0, error=0
- Second load at the top of RAM: start with load_base=E, stream 02,38,23,5B →
  - RAM[E]=38, RAM[F]=23; RAM[0..3] unchanged; done=1
- Wrap and bad checksum:
  - load_base=F, stream 02,AA,BB,00 → RAM[F]=AA, RAM[0]=BB, error=1, cpu_hold=1, done=0.
  - Retry with checksum 65 → done=1.
- Header errors:
  - LEN=00 → error=1, no ram_we.
  - LEN=11 (DEPTH=16) → error=1, no ram_we.
- ZERO_FILL=1 with RAM pre-filled FF: load_base=0, stream 02,11,22,33 →
  - RAM[0]=11, RAM[1]=22, RAM[2..F]=00; 14 fill writes; then done=1
- Reset mid-DATA after two payload words →
  - cpu_hold=1, done=0, error=0, in_ready=0 immediately
  - the two written words remain
  - a fresh start performs a full load
